aes_inv_round_iter: RTL and testbench
=====================================

// Module: aes_inv_round_iter
// PURPOSE
//   Iterative AES-128 inverse cipher (FIPS-197 §5.3). Decryption counterpart of the encrypt round datapath.
//   Takes the ciphertext and the round-10 key, then runs one round per clock.
//   The key schedule runs backwards on the fly (rk10 -> rk0), so no round-key storage is needed.
//   Sits in the AES core beside the encrypt path, and is driven by the AXI-side control FSM.
// PARAMETERS
//   NR        10   number of rounds; only 10 (AES-128) supported, other values are illegal
// PORTS
//   iClk         in   1    clock, all state updates on rising edge
//   iRst         in   1    asynchronous, active-high reset
//   iStart       in   1    start request; accepted only while oBusy==0
//   iCipherText  in   128  ciphertext block; sampled on the accepting edge
//   iLastRoundKey in  128  round-10 key rk10; sampled on the accepting edge
//   oPlainText   out  128  result block; registered, holds until the next completion
//   oRoundKey0   out  128  recovered rk0 (cipher key); registered with oPlainText
//   oBusy        out  1    high from the accepting edge until the last-round edge
//   oDone        out  1    one-cycle pulse: oPlainText/oRoundKey0 newly valid
// BEHAVIOUR
//   Byte order: bits [127:120] = byte 0 = s[0][0]. State is column-major as in FIPS-197; word w0 = [127:96].
//   Reset (async, iRst=1): FSM->IDLE; rState, rKey, oPlainText, oRoundKey0 all 0; rRnd=0; oBusy=0; oDone=0.
//   FSM has 2 states:
//     - IDLE: oBusy=0. On iStart=1 at edge t: rState<=iCipherText^iLastRoundKey, rKey<=iLastRoundKey, rRnd<=10, go to RUN.
//     - RUN: oBusy=1. iStart is ignored (no queueing, no error).
//   Each edge in RUN:
//     - Kp = InvKeyStep(rKey, rRnd)
//     - T  = InvSubBytes(InvShiftRows(rState)) ^ Kp
//     - rState <= (rRnd>1) ? InvMixColumns(T) : T
//     - rKey <= Kp; rRnd <= rRnd-1
//   When rRnd==1 at the edge:
//     - oPlainText<=T, oRoundKey0<=Kp, oDone<=1
//     - FSM->IDLE; rState, rKey, rRnd are don't-care
//   InvKeyStep({w0,w1,w2,w3}, r):
//     - v3=w3^w2, v2=w2^w1, v1=w1^w0
//     - v0 = w0 ^ SubWord(RotWord(v3)) ^ {Rcon[r],24'h0}
//     - returns {v0,v1,v2,v3}
//   Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. SubWord uses the forward S-box; InvSubBytes uses the inverse S-box.
//   InvMixColumns: per column, multiply by {0e,0b,0d,09} over GF(2^8), reduction poly 0x11b.
//   Latency: start accepted at edge t -> last round at edge t+10 -> oDone high in the cycle after edge t+10, exactly 1 cycle.
//   oBusy is high for the 10 cycles after edge t and falls at edge t+10, together with the oDone rise.
//   Back-to-back: iStart during the oDone cycle is accepted (FSM is already IDLE).
//   Throughput: 1 block / 11 cycles.
//   Reset mid-operation: the operation is aborted and outputs clear to 0. No oDone pulse is produced for the aborted block.
//   Inputs iCipherText/iLastRoundKey may change freely after the accepting edge.
//   All datapath logic between registers is combinational. No multicycle paths.
// TESTING
//   1. FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, rk10=13111d7fe3944a17f307a78b4d2b30c5
//      -> oPlainText=00112233445566778899aabbccddeeff, oRoundKey0=000102030405060708090a0b0c0d0e0f, oDone 11 cycles after start.
//   2. FIPS-197 App.B: ct=3925841d02dc09fbdc118597196a0b32, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6
//      -> pt=3243f6a8885a308d313198a2e0370734, key0=2b7e151628aed2a6abf7158809cf4f3c.
//   3. Start test 1, pulse iStart with test-2 data at cycle 4
//      -> ignored; result is test-1 pt; oBusy stays 1 for exactly 10 cycles.
//   4. Back-to-back: test-1 start, then test-2 start asserted in the oDone cycle
//      -> two oDone pulses 11 cycles apart with the correct pts; oPlainText holds test-1 pt in between.
//   5. Assert iRst at cycle 5 of a run (asynchronously, mid-cycle)
//      -> outputs go to 0 immediately; no oDone pulse; a new start afterwards gives the correct result.
//   6. Random: 1000 random (pt,key) pairs encrypted by the C reference model, ct + rk10 applied
//      -> pt and key0 match, oDone is always 1 cycle wide.

Source files
------------

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock.
// The key schedule is unwound on the fly from rk10 back to rk0.
module aes_inv_round_iter #(
  parameter int NR = 10
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iCipherText,
  input  logic [127:0] iLastRoundKey,
  output logic [127:0] oPlainText,
  output logic [127:0] oRoundKey0,
  output logic         oBusy,
  output logic         oDone
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [3:0]   r_rnd;

  logic [127:0] w_kp;
  logic [127:0] w_t;
  logic [127:0] w_mix;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte k of the block lives at packed index 15-k; row r of column c is byte 4c+r.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [15:0][7:0] b;
    logic [15:0][7:0] o;
    b = s;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[15-(4*c+r)] = inv_sbox(b[15-(4*((c-r+4)%4)+r)]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [15:0][7:0] b;
    logic [15:0][7:0] o;
    logic [7:0] a0, a1, a2, a3;
    b = s;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[15-4*c];
      a1 = b[14-4*c];
      a2 = b[13-4*c];
      a3 = b[12-4*c];
      o[15-4*c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[14-4*c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[13-4*c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[12-4*c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round key r-1 from round key r: undo the xor chain first, then the w0 core.
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] v0, v1, v2, v3;
    v3 = k[31:0]   ^ k[63:32];
    v2 = k[63:32]  ^ k[95:64];
    v1 = k[95:64]  ^ k[127:96];
    v0 = k[127:96] ^ sub_word({v3[23:0], v3[31:24]}) ^ {rcon(r), 24'h000000};
    return {v0, v1, v2, v3};
  endfunction

  assign w_kp  = inv_key_step(r_key, r_rnd);
  assign w_t   = inv_sub_shift(r_state) ^ w_kp;
  assign w_mix = inv_mix_columns(w_t);

  // Round register stage: one inverse round per edge while running
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_fsm      <= S_IDLE;
      r_state    <= '0;
      r_key      <= '0;
      r_rnd      <= '0;
      oPlainText <= '0;
      oRoundKey0 <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (iStart) begin
            r_state <= iCipherText ^ iLastRoundKey;
            r_key   <= iLastRoundKey;
            r_rnd   <= 4'(NR);
            oBusy   <= 1'b1;
            r_fsm   <= S_RUN;
          end
        end
        S_RUN: begin
          r_state <= (r_rnd > 4'd1) ? w_mix : w_t;
          r_key   <= w_kp;
          r_rnd   <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) begin
            oPlainText <= w_t;
            oRoundKey0 <= w_kp;
            oDone      <= 1'b1;
            oBusy      <= 1'b0;
            r_fsm      <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Directed bench for aes_inv_round_iter using the FIPS-197 decryption vectors.
module tb_aes_inv_round_iter;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         iClk = 1'b0;
  logic         iRst = 1'b1;
  logic         iStart = 1'b0;
  logic [127:0] iCipherText = '0;
  logic [127:0] iLastRoundKey = '0;
  logic [127:0] oPlainText;
  logic [127:0] oRoundKey0;
  logic         oBusy;
  logic         oDone;

  int n_checks = 0;
  int n_errors = 0;

  aes_inv_round_iter #(.NR(10)) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iStart        (iStart),
    .iCipherText   (iCipherText),
    .iLastRoundKey (iLastRoundKey),
    .oPlainText    (oPlainText),
    .oRoundKey0    (oRoundKey0),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  always #5 iClk = ~iClk;

  // Returns 1 ns after the accepting edge with iStart already dropped.
  task automatic start_block(input logic [127:0] ct, input logic [127:0] rk);
    @(negedge iClk);
    iCipherText   = ct;
    iLastRoundKey = rk;
    iStart        = 1'b1;
    @(posedge iClk);
    #1;
    iStart        = 1'b0;
    iCipherText   = '0;
    iLastRoundKey = '0;
  endtask

  // Edges counted after the call until oDone is seen; -1 when the budget runs out.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge iClk);
      #1;
      if (oDone) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    n_checks++;
    if (oBusy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    n_checks++;
    if (oDone !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", oDone); end
    n_checks++;
    if (oPlainText !== 128'h0) begin n_errors++; $display("FAIL reset_pt: got %h expected 0", oPlainText); end
    n_checks++;
    if (oRoundKey0 !== 128'h0) begin n_errors++; $display("FAIL reset_key0: got %h expected 0", oRoundKey0); end
    @(negedge iClk);
    iRst = 1'b0;
  endtask

  task automatic test_fips_c1();
    int busy_cnt, done_cnt, done_at;
    start_block(C1_CT, C1_RK);
    busy_cnt = oBusy ? 1 : 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge iClk);
      #1;
      if (oBusy) busy_cnt++;
      if (oDone) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    n_checks++;
    if (done_at !== 10) begin n_errors++; $display("FAIL c1_latency: got %0d expected 10", done_at); end
    n_checks++;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL c1_done_width: got %0d expected 1", done_cnt); end
    n_checks++;
    if (busy_cnt !== 10) begin n_errors++; $display("FAIL c1_busy_cycles: got %0d expected 10", busy_cnt); end
    n_checks++;
    if (oPlainText !== C1_PT) begin n_errors++; $display("FAIL c1_pt: got %h expected %h", oPlainText, C1_PT); end
    n_checks++;
    if (oRoundKey0 !== C1_K0) begin n_errors++; $display("FAIL c1_key0: got %h expected %h", oRoundKey0, C1_K0); end
  endtask

  task automatic test_fips_b();
    int n;
    start_block(B_CT, B_RK);
    wait_done(n);
    n_checks++;
    if (n !== 10) begin n_errors++; $display("FAIL b_latency: got %0d expected 10", n); end
    n_checks++;
    if (oPlainText !== B_PT) begin n_errors++; $display("FAIL b_pt: got %h expected %h", oPlainText, B_PT); end
    n_checks++;
    if (oRoundKey0 !== B_K0) begin n_errors++; $display("FAIL b_key0: got %h expected %h", oRoundKey0, B_K0); end
  endtask

  task automatic test_ignore_start();
    int busy_cnt, done_at;
    start_block(C1_CT, C1_RK);
    busy_cnt = oBusy ? 1 : 0;
    done_at  = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) begin
        @(negedge iClk);
        iStart        = 1'b1;
        iCipherText   = B_CT;
        iLastRoundKey = B_RK;
      end
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      if (oBusy) busy_cnt++;
      if (oDone && done_at < 0) done_at = i;
    end
    n_checks++;
    if (busy_cnt !== 10) begin n_errors++; $display("FAIL ign_busy_cycles: got %0d expected 10", busy_cnt); end
    n_checks++;
    if (done_at !== 10) begin n_errors++; $display("FAIL ign_latency: got %0d expected 10", done_at); end
    n_checks++;
    if (oPlainText !== C1_PT) begin n_errors++; $display("FAIL ign_pt: got %h expected %h", oPlainText, C1_PT); end
    n_checks++;
    if (oRoundKey0 !== C1_K0) begin n_errors++; $display("FAIL ign_key0: got %h expected %h", oRoundKey0, C1_K0); end
  endtask

  task automatic test_back_to_back();
    int n1, done_at, done_cnt;
    start_block(C1_CT, C1_RK);
    wait_done(n1);
    n_checks++;
    if (n1 !== 10) begin n_errors++; $display("FAIL b2b_first_latency: got %0d expected 10", n1); end
    n_checks++;
    if (oPlainText !== C1_PT) begin n_errors++; $display("FAIL b2b_first_pt: got %h expected %h", oPlainText, C1_PT); end
    start_block(B_CT, B_RK);
    n_checks++;
    if (oBusy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept_busy: got %b expected 1", oBusy); end
    n_checks++;
    if (oDone !== 1'b0) begin n_errors++; $display("FAIL b2b_done_width: got %b expected 0", oDone); end
    done_at  = -1;
    done_cnt = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge iClk);
      #1;
      if (oDone) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 5) begin
        n_checks++;
        if (oPlainText !== C1_PT) begin n_errors++; $display("FAIL b2b_hold_pt: got %h expected %h", oPlainText, C1_PT); end
      end
    end
    n_checks++;
    if (done_at !== 10) begin n_errors++; $display("FAIL b2b_second_latency: got %0d expected 10", done_at); end
    n_checks++;
    if (done_cnt !== 1) begin n_errors++; $display("FAIL b2b_second_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (oPlainText !== B_PT) begin n_errors++; $display("FAIL b2b_second_pt: got %h expected %h", oPlainText, B_PT); end
  endtask

  task automatic test_reset_mid();
    int done_cnt, n;
    start_block(C1_CT, C1_RK);
    repeat (5) @(posedge iClk);
    #3;
    iRst = 1'b1;
    #1;
    n_checks++;
    if (oPlainText !== 128'h0) begin n_errors++; $display("FAIL rstmid_pt: got %h expected 0", oPlainText); end
    n_checks++;
    if (oRoundKey0 !== 128'h0) begin n_errors++; $display("FAIL rstmid_key0: got %h expected 0", oRoundKey0); end
    n_checks++;
    if (oBusy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b expected 0", oBusy); end
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge iClk);
      #1;
      if (oDone) done_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    start_block(B_CT, B_RK);
    wait_done(n);
    n_checks++;
    if (n !== 10) begin n_errors++; $display("FAIL rstmid_restart_latency: got %0d expected 10", n); end
    n_checks++;
    if (oPlainText !== B_PT) begin n_errors++; $display("FAIL rstmid_restart_pt: got %h expected %h", oPlainText, B_PT); end
    n_checks++;
    if (oRoundKey0 !== B_K0) begin n_errors++; $display("FAIL rstmid_restart_key0: got %h expected %h", oRoundKey0, B_K0); end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
